// File: rtl/vcbn_mod_cnt_if.sv
// Bus bundle for the modulo up/down counter: control and load data in,
// count, terminal-count, cascade enable and sticky overflow out.
interface vcbn_mod_cnt_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ce;
    logic             up;
    logic             L;
    logic [WIDTH-1:0] di;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             CEO;
    logic             OVF;

    modport master (
        output ce, up, L, di,
        input  Q, TC, CEO, OVF
    );

    modport slave (
        input  ce, up, L, di,
        output Q, TC, CEO, OVF
    );
endinterface

// File: rtl/vcbn_mod_cnt.sv
// Modulo-(MAXV+1) up/down counter with parallel load, wrap or saturate at
// the boundaries, terminal-count and cascade-enable outputs, and a sticky
// boundary-crossing flag.
module vcbn_mod_cnt #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] MAXV  = '1,
    parameter bit               SAT   = 1'b0
) (
    input logic           clk,
    input logic           clr,
    vcbn_mod_cnt_if.slave bus
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_d;
    logic             ovf;
    logic             ovf_d;
    logic             at_max;
    logic             at_zero;
    logic             tc;

    assign at_max  = (q == MAXV);
    assign at_zero = (q == '0);

    // Next count: load (clamped to MAXV) beats count; boundaries use explicit compares.
    always_comb begin
        q_d   = q;
        ovf_d = ovf;
        if (bus.L) begin
            q_d = (bus.di > MAXV) ? MAXV : bus.di;
        end else if (bus.ce) begin
            if (bus.up) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    q_d   = SAT ? MAXV : '0;
                end else begin
                    q_d = q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    ovf_d = 1'b1;
                    q_d   = SAT ? '0 : MAXV;
                end else begin
                    q_d = q - WIDTH'(1);
                end
            end
        end
    end

    // State register; clr overrides load and count on the same edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_d;
            ovf <= ovf_d;
        end
    end

    // Terminal count tracks direction; cascade only fires on a real boundary step.
    always_comb begin
        tc      = bus.up ? at_max : at_zero;
        bus.TC  = tc;
        bus.CEO = bus.ce & tc & ~bus.L & ~clr;
        bus.Q   = q;
        bus.OVF = ovf;
    end

endmodule

// File: tb/tb_vcbn_mod_cnt.sv
// Directed bench for vcbn_mod_cnt: decade count, down wrap, load priority,
// saturate mode, two-stage cascade and mid-sequence clear.
module tb_vcbn_mod_cnt;

    logic clk;
    logic clr;
    logic clr_sat;
    logic clr_cas;
    int   total;
    int   bad;

    vcbn_mod_cnt_if #(.WIDTH(4)) dut_bus ();
    vcbn_mod_cnt_if #(.WIDTH(4)) sat_bus ();
    vcbn_mod_cnt_if #(.WIDTH(4)) lo_bus ();
    vcbn_mod_cnt_if #(.WIDTH(4)) hi_bus ();

    vcbn_mod_cnt #(.WIDTH(4), .MAXV(4'd9), .SAT(1'b0)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (dut_bus.slave)
    );

    vcbn_mod_cnt #(.WIDTH(4), .MAXV(4'd9), .SAT(1'b1)) u_sat (
        .clk (clk),
        .clr (clr_sat),
        .bus (sat_bus.slave)
    );

    vcbn_mod_cnt #(.WIDTH(4), .MAXV(4'd9), .SAT(1'b0)) u_lo (
        .clk (clk),
        .clr (clr_cas),
        .bus (lo_bus.slave)
    );

    vcbn_mod_cnt #(.WIDTH(4), .MAXV(4'd9), .SAT(1'b0)) u_hi (
        .clk (clk),
        .clr (clr_cas),
        .bus (hi_bus.slave)
    );

    assign hi_bus.ce = lo_bus.CEO;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr        = 1'b1;
        dut_bus.ce = 1'b1;
        dut_bus.up = 1'b1;
        dut_bus.L  = 1'b1;
        dut_bus.di = 4'd5;
        tick();
        total++;
        if (dut_bus.Q !== 4'd0 || dut_bus.OVF !== 1'b0) begin
            bad++;
            $display("FAIL reset_state Q=%0d OVF=%b want Q=0 OVF=0", dut_bus.Q, dut_bus.OVF);
        end
        dut_bus.L  = 1'b0;
        dut_bus.up = 1'b0;
        #1;
        total++;
        if (dut_bus.TC !== 1'b1 || dut_bus.CEO !== 1'b0) begin
            bad++;
            $display("FAIL reset_tc_ceo TC=%b CEO=%b want TC=1 CEO=0", dut_bus.TC, dut_bus.CEO);
        end
    endtask

    task automatic test_up_count();
        logic [3:0] cur;
        clr        = 1'b1;
        dut_bus.L  = 1'b0;
        dut_bus.ce = 1'b1;
        dut_bus.up = 1'b1;
        tick();
        clr = 1'b0;
        cur = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            total++;
            if (dut_bus.TC !== (cur == 4'd9) || dut_bus.CEO !== (cur == 4'd9)) begin
                bad++;
                $display("FAIL up_tc_ceo at Q=%0d TC=%b CEO=%b want %b", cur, dut_bus.TC,
                         dut_bus.CEO, (cur == 4'd9));
            end
            tick();
            cur = 4'(i % 10);
            total++;
            if (dut_bus.Q !== cur || dut_bus.OVF !== (i == 10)) begin
                bad++;
                $display("FAIL up_count step %0d Q=%0d OVF=%b want Q=%0d OVF=%b", i, dut_bus.Q,
                         dut_bus.OVF, cur, (i == 10));
            end
        end
    endtask

    task automatic test_down_wrap();
        clr = 1'b1;
        tick();
        clr        = 1'b0;
        dut_bus.L  = 1'b1;
        dut_bus.di = 4'd0;
        dut_bus.ce = 1'b0;
        tick();
        dut_bus.L  = 1'b0;
        dut_bus.up = 1'b0;
        dut_bus.ce = 1'b1;
        #1;
        total++;
        if (dut_bus.Q !== 4'd0 || dut_bus.TC !== 1'b1 || dut_bus.CEO !== 1'b1) begin
            bad++;
            $display("FAIL down_tc Q=%0d TC=%b CEO=%b want Q=0 TC=1 CEO=1", dut_bus.Q,
                     dut_bus.TC, dut_bus.CEO);
        end
        tick();
        total++;
        if (dut_bus.Q !== 4'd9 || dut_bus.OVF !== 1'b1) begin
            bad++;
            $display("FAIL down_wrap Q=%0d OVF=%b want Q=9 OVF=1", dut_bus.Q, dut_bus.OVF);
        end
        // Load must not clear the sticky flag.
        dut_bus.L  = 1'b1;
        dut_bus.di = 4'd3;
        tick();
        total++;
        if (dut_bus.Q !== 4'd3 || dut_bus.OVF !== 1'b1) begin
            bad++;
            $display("FAIL load_keeps_ovf Q=%0d OVF=%b want Q=3 OVF=1", dut_bus.Q, dut_bus.OVF);
        end
        dut_bus.L = 1'b0;
        tick();
        total++;
        if (dut_bus.Q !== 4'd2) begin
            bad++;
            $display("FAIL down_step Q=%0d want 2", dut_bus.Q);
        end
        dut_bus.up = 1'b1;
        tick();
        total++;
        if (dut_bus.Q !== 4'd3) begin
            bad++;
            $display("FAIL dir_change Q=%0d want 3", dut_bus.Q);
        end
    endtask

    task automatic test_load_priority();
        dut_bus.L  = 1'b1;
        dut_bus.ce = 1'b1;
        dut_bus.up = 1'b1;
        dut_bus.di = 4'hC;
        tick();
        total++;
        if (dut_bus.Q !== 4'd9) begin
            bad++;
            $display("FAIL load_clamp Q=%0d want 9", dut_bus.Q);
        end
        total++;
        if (dut_bus.TC !== 1'b1 || dut_bus.CEO !== 1'b0) begin
            bad++;
            $display("FAIL load_ceo TC=%b CEO=%b want TC=1 CEO=0", dut_bus.TC, dut_bus.CEO);
        end
        dut_bus.ce = 1'b0;
        dut_bus.di = 4'd5;
        tick();
        total++;
        if (dut_bus.Q !== 4'd5) begin
            bad++;
            $display("FAIL load_plain Q=%0d want 5", dut_bus.Q);
        end
        clr        = 1'b1;
        dut_bus.di = 4'd7;
        tick();
        total++;
        if (dut_bus.Q !== 4'd0) begin
            bad++;
            $display("FAIL clr_over_load Q=%0d want 0", dut_bus.Q);
        end
        clr       = 1'b0;
        dut_bus.L = 1'b0;
    endtask

    task automatic test_saturate();
        logic [3:0] exp_q [3];
        logic       exp_o [3];
        exp_q[0] = 4'd9; exp_q[1] = 4'd9; exp_q[2] = 4'd9;
        exp_o[0] = 1'b0; exp_o[1] = 1'b1; exp_o[2] = 1'b1;
        clr_sat    = 1'b1;
        sat_bus.L  = 1'b0;
        sat_bus.ce = 1'b0;
        sat_bus.up = 1'b1;
        sat_bus.di = 4'd8;
        tick();
        clr_sat   = 1'b0;
        sat_bus.L = 1'b1;
        tick();
        sat_bus.L  = 1'b0;
        sat_bus.ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (sat_bus.Q !== exp_q[i] || sat_bus.OVF !== exp_o[i]) begin
                bad++;
                $display("FAIL sat_up edge %0d Q=%0d OVF=%b want Q=%0d OVF=%b", i, sat_bus.Q,
                         sat_bus.OVF, exp_q[i], exp_o[i]);
            end
        end
        sat_bus.up = 1'b0;
        tick();
        total++;
        if (sat_bus.Q !== 4'd8 || sat_bus.OVF !== 1'b1) begin
            bad++;
            $display("FAIL sat_down Q=%0d OVF=%b want Q=8 OVF=1", sat_bus.Q, sat_bus.OVF);
        end
        sat_bus.L  = 1'b1;
        sat_bus.di = 4'd0;
        tick();
        sat_bus.L = 1'b0;
        tick();
        total++;
        if (sat_bus.Q !== 4'd0) begin
            bad++;
            $display("FAIL sat_floor Q=%0d want 0", sat_bus.Q);
        end
        sat_bus.ce = 1'b0;
    endtask

    task automatic test_cascade();
        int exp_lo;
        int exp_hi;
        clr_cas   = 1'b1;
        lo_bus.ce = 1'b1;
        lo_bus.up = 1'b1;
        lo_bus.L  = 1'b0;
        lo_bus.di = 4'd0;
        hi_bus.up = 1'b1;
        hi_bus.L  = 1'b0;
        hi_bus.di = 4'd0;
        tick();
        clr_cas = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            #1;
            total++;
            if (hi_bus.ce !== (lo_bus.Q == 4'd9)) begin
                bad++;
                $display("FAIL cascade_ce lo=%0d hi_ce=%b want %b", lo_bus.Q, hi_bus.ce,
                         (lo_bus.Q == 4'd9));
            end
            tick();
            exp_lo = i % 10;
            exp_hi = (i / 10) % 10;
            total++;
            if (lo_bus.Q !== 4'(exp_lo) || hi_bus.Q !== 4'(exp_hi)) begin
                bad++;
                $display("FAIL cascade step %0d got %0d%0d want %0d%0d", i, hi_bus.Q, lo_bus.Q,
                         exp_hi, exp_lo);
            end
        end
        lo_bus.ce = 1'b0;
    endtask

    task automatic test_mid_reset();
        clr        = 1'b1;
        dut_bus.L  = 1'b0;
        dut_bus.ce = 1'b0;
        tick();
        clr        = 1'b0;
        dut_bus.L  = 1'b1;
        dut_bus.di = 4'd9;
        tick();
        dut_bus.L  = 1'b0;
        dut_bus.ce = 1'b1;
        dut_bus.up = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        total++;
        if (dut_bus.Q !== 4'd6 || dut_bus.OVF !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup Q=%0d OVF=%b want Q=6 OVF=1", dut_bus.Q, dut_bus.OVF);
        end
        clr        = 1'b1;
        dut_bus.L  = 1'b1;
        dut_bus.di = 4'd3;
        tick();
        total++;
        if (dut_bus.Q !== 4'd0 || dut_bus.OVF !== 1'b0) begin
            bad++;
            $display("FAIL mid_clr Q=%0d OVF=%b want Q=0 OVF=0", dut_bus.Q, dut_bus.OVF);
        end
        clr       = 1'b0;
        dut_bus.L = 1'b0;
        tick();
        total++;
        if (dut_bus.Q !== 4'd1) begin
            bad++;
            $display("FAIL mid_resume Q=%0d want 1", dut_bus.Q);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        clr        = 1'b1;
        clr_sat    = 1'b1;
        clr_cas    = 1'b1;
        dut_bus.ce = 1'b0;
        dut_bus.up = 1'b1;
        dut_bus.L  = 1'b0;
        dut_bus.di = 4'd0;
        sat_bus.ce = 1'b0;
        sat_bus.up = 1'b1;
        sat_bus.L  = 1'b0;
        sat_bus.di = 4'd0;
        lo_bus.ce  = 1'b0;
        lo_bus.up  = 1'b1;
        lo_bus.L   = 1'b0;
        lo_bus.di  = 4'd0;
        hi_bus.up  = 1'b1;
        hi_bus.L   = 1'b0;
        hi_bus.di  = 4'd0;
        tick();
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load_priority();
        test_saturate();
        test_cascade();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
